seq_alu: RTL
============

Name: seq_alu

Overview:
Parametrised next-generation ALU with a registered result stage and an iterative multiply/divide engine.
- Accepts one operation per START pulse.
- Single-cycle ops (add/sub/logic/shift/slt) complete in 1 cycle; multu/divu run WIDTH iteration cycles.
- Results are held until the next accepted operation.
- Sits in the execute stage of the multi-cycle datapath; the controller stalls on BUSY.

Parameters:
- WIDTH, 32, operand/result width; power of 2, >= 8.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- START  in  1  request; sampled only when BUSY=0.
- A  in  WIDTH  operand A (dividend, multiplicand, shift source).
- B  in  WIDTH  operand B (divisor, multiplier, shift amount B[SHW-1:0]).
- ALUC  in  4  opcode.
- OUT  out  WIDTH  result / product low / quotient.
- HI  out  WIDTH  product high / remainder; 0 for single-cycle ops.
- ZERO  out  1  OUT==0 (defined ops only).
- OF  out  1  signed overflow.
- DIVZ  out  1  divide by zero.
- BUSY  out  1  iterative op in progress.
- DONE  out  1  one-cycle pulse: results valid.

Behaviour:
- Reset: the synchronous active-high RST clears OUT, HI, ZERO, OF, DIVZ, BUSY, DONE and all internal state, and enters IDLE.
- RST during RUN aborts the operation and emits no DONE.
- Opcodes:
  - 0000 add, 0001 sub, 0010 or, 0011 and.
  - 0100 sll, 0101 srl, 0110 sra (amount = B[SHW-1:0], upper bits ignored).
  - 0111 slt: signed A<B gives OUT=1, else 0.
  - 1000 multu: {HI,OUT} = A*B, unsigned, 2*WIDTH bits.
  - 1001 divu: OUT = A/B, HI = A%B, unsigned.
  - Any other opcode gives OUT=0, HI=0, ZERO=0, OF=0, DIVZ=0, with DONE after 1 cycle.
- OF:
  - add: A, B same sign and OUT sign differs.
  - sub: A, B signs differ and OUT sign differs from A.
  - 0 for all other ops.
- DIVZ is 0 for every op except divide by zero.
- States:
  - IDLE: START=1 at edge k latches A, B, ALUC.
    - Single-cycle op: results are registered and DONE=1 from edge k; stay in IDLE; BUSY stays 0.
    - multu/divu with B!=0: go to RUN; BUSY=1 from edge k; counter=WIDTH.
    - divu with B==0: 1-cycle completion; OUT = all ones, HI = A, DIVZ=1, ZERO=0.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle; counter decrements.
    - The step that brings counter to 0 transitions to IDLE.
    - Results, ZERO and DONE=1 appear at edge k+WIDTH; BUSY=0 at the same edge.
- DONE lasts exactly one cycle. Outputs other than DONE hold until the next accepted START.
- START while BUSY=1 is ignored and not queued. START in the same cycle DONE=1 is accepted (back-to-back allowed).
- Operand/opcode changes after acceptance have no effect.
- Multu/divu results are all-or-nothing: OUT/HI keep their previous values during RUN and update only on the completion edge.

Optional Feature:
- Macro SEQ_ALU_SIGNED_MD_EN.
- Defined: adds opcodes 1010 mult (signed 2*WIDTH product) and 1011 div (signed, truncate toward zero, remainder takes the sign of the dividend).
  - Both use the same iterative engine on magnitudes; sign is fixed on the completion edge with no extra cycles.
  - Same latency as the unsigned versions.
  - div by 0: same rule as divu.
  - div of MIN by -1: OUT=MIN, HI=0, OF=1.
- Undefined: 1010/1011 decode as undefined opcodes.

Test Plan:
- add A=0x7FFFFFFF, B=1, START at edge k -> at edge k: OUT=0x80000000, OF=1, ZERO=0, DONE pulse, BUSY never 1.
- multu A=B=0xFFFFFFFF -> BUSY high for 32 cycles, DONE at edge k+32, HI=0xFFFFFFFE, OUT=0x00000001; a START held high mid-run is ignored.
- divu 100/7 -> OUT=14, HI=2, DIVZ=0 at edge k+32; then divu 5/0 -> at edge k: OUT=0xFFFFFFFF, HI=5, DIVZ=1.
- sra A=0x80000000, B=0x24 -> OUT=0xF8000000 (shift 4); sub 0-0 -> ZERO=1, OF=0; slt A=0xFFFFFFFF, B=1 -> OUT=1.
- multu 3*5, RST at cycle k+10 -> no DONE, all outputs 0, BUSY=0; subsequent add 2+2 -> OUT=4.
- With SEQ_ALU_SIGNED_MD_EN: div -7/2 -> OUT=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> OUT=0x80000000, HI=0, OF=1; mult -3*4 -> {HI,OUT}=0xFFFFFFFF_FFFFFFF4.

Source files
------------

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle between the execute-stage controller and seq_alu.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       aluc;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             of;
    logic             divz;
    logic             busy;
    logic             done;
    modport master(output start, a, b, aluc, input out, hi, zero, of, divz, busy, done);
    modport slave(input start, a, b, aluc, output out, hi, zero, of, divz, busy, done);
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered single-cycle ALU plus a WIDTH-cycle shift-add / restoring-divide engine.
// Defining SEQ_ALU_SIGNED_MD_EN adds signed mult (1010) and div (1011) on the same engine.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
`ifdef SEQ_ALU_SIGNED_MD_EN
    localparam logic SGN_EN = 1'b1;
`else
    localparam logic SGN_EN = 1'b0;
`endif
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [SHW:0] cnt;
    logic [WIDTH-1:0] m, r, q, nr, nq, fin_out, fin_hi;
    logic [WIDTH-1:0] sum, dif, sc_out, sc_hi, abs_a, abs_b;
    logic [WIDTH:0] acc, rs, dd;
    logic [2*WIDTH-1:0] prod;
    logic [SHW-1:0] sh;
    logic run_div, neg_q, neg_r, ovf, last;
    logic sgn, is_mul, is_div, go_run, sc_of, sc_divz, sc_def;
    assign sgn = SGN_EN && bus.aluc[3:1] == 3'b101;
    assign is_mul = bus.aluc == 4'b1000 || (sgn && !bus.aluc[0]);
    assign is_div = bus.aluc == 4'b1001 || (sgn && bus.aluc[0]);
    assign go_run = is_mul || (is_div && bus.b != '0);
    assign sum = bus.a + bus.b;
    assign dif = bus.a - bus.b;
    assign sh = bus.b[SHW-1:0];
    assign abs_a = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign abs_b = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    always_comb begin
        sc_out = '0;
        sc_hi = '0;
        sc_of = 1'b0;
        sc_divz = 1'b0;
        sc_def = 1'b1;
        case (bus.aluc)
            4'b0000: begin
                sc_out = sum;
                sc_of = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0001: begin
                sc_out = dif;
                sc_of = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0010: sc_out = bus.a | bus.b;
            4'b0011: sc_out = bus.a & bus.b;
            4'b0100: sc_out = bus.a << sh;
            4'b0101: sc_out = bus.a >> sh;
            4'b0110: sc_out = $signed(bus.a) >>> sh;
            4'b0111: sc_out = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            default: begin
                // Only divide-by-zero reaches here with real results; the rest are undefined.
                sc_def = 1'b0;
                if (is_div) begin
                    sc_out = '1;
                    sc_hi = bus.a;
                    sc_divz = 1'b1;
                end
            end
        endcase
    end
    assign acc = {1'b0, r} + {1'b0, (q[0] ? m : {WIDTH{1'b0}})};
    assign rs = {r, q[WIDTH-1]};
    assign dd = rs - {1'b0, m};
    assign nr = run_div ? (dd[WIDTH] ? rs[WIDTH-1:0] : dd[WIDTH-1:0]) : acc[WIDTH:1];
    assign nq = run_div ? {q[WIDTH-2:0], ~dd[WIDTH]} : {acc[0], q[WIDTH-1:1]};
    assign last = cnt == (SHW+1)'(1);
    // Signs are applied to the final magnitudes on the completion edge only.
    assign prod = neg_q ? -{nr, nq} : {nr, nq};
    assign fin_out = run_div ? (neg_q ? -nq : nq) : prod[WIDTH-1:0];
    assign fin_hi = run_div ? (neg_r ? -nr : nr) : prod[2*WIDTH-1:WIDTH];
    assign bus.busy = state == RUN;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (state == IDLE && bus.start && go_run) state_n = RUN;
        else if (state == RUN && last) state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            m <= '0;
            r <= '0;
            q <= '0;
            run_div <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            ovf <= 1'b0;
            bus.out <= '0;
            bus.hi <= '0;
            bus.zero <= 1'b0;
            bus.of <= 1'b0;
            bus.divz <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE && bus.start) begin
                if (go_run) begin
                    m <= is_div ? abs_b : abs_a;
                    q <= is_div ? abs_a : abs_b;
                    r <= '0;
                    cnt <= (SHW+1)'(WIDTH);
                    run_div <= is_div;
                    neg_q <= sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_r <= sgn && bus.a[WIDTH-1];
                    ovf <= sgn && is_div && bus.a == {1'b1, {(WIDTH-1){1'b0}}} && &bus.b;
                end else begin
                    bus.out <= sc_out;
                    bus.hi <= sc_hi;
                    bus.zero <= sc_def && sc_out == '0;
                    bus.of <= sc_of;
                    bus.divz <= sc_divz;
                    bus.done <= 1'b1;
                end
            end else if (state == RUN) begin
                r <= nr;
                q <= nq;
                cnt <= cnt - 1'b1;
                if (last) begin
                    bus.out <= fin_out;
                    bus.hi <= fin_hi;
                    bus.zero <= fin_out == '0;
                    bus.of <= ovf;
                    bus.divz <= 1'b0;
                    bus.done <= 1'b1;
                end
            end
        end
    end
endmodule
